arid_seq_tagger: RTL
====================

Name: arid_seq_tagger

Overview:
- Upstream partner of the per-ID read-response sequence counter on the AXI read path.
- Accepts AR requests from one master and tags each with `{seq, ID}` on ARID. seq is a free-running, in-order allocation number, so the downstream counter can match RID high bits against its expected count.
- Tracks outstanding read bursts and back-pressures the master when the sequence space is exhausted.
- Presents AR through a one-deep register slice.

Parameters:
- ID, 2'b00, master ID placed in the low ARID bits.
- ID_width, 2, width of the ID field.
- seq_width, 4, width of the sequence field; maximum outstanding = 2**seq_width.
- ADDR_WIDTH, 32, ARADDR width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_ARVALID  in  1  master request valid.
- s_ARREADY  out  1  request accepted this cycle when high with s_ARVALID.
- s_ARADDR  in  ADDR_WIDTH  read address.
- s_ARLEN  in  8  burst length − 1.
- s_ARSIZE  in  3  beat size.
- s_ARBURST  in  2  burst type.
- m_ARVALID  out  1  tagged request valid toward interconnect.
- m_ARREADY  in  1  interconnect accepts.
- m_ARID  out  ID_width+seq_width  {seq, ID}; ID in [ID_width-1:0].
- m_ARADDR / m_ARLEN / m_ARSIZE / m_ARBURST  out  as s_*  registered copies.
- RID  in  ID_width+seq_width  response ID.
- RVALID, RREADY, RLAST  in  1 each  R channel handshake, observed only.
- outstanding  out  seq_width+1  bursts allocated but not completed.
- full  out  1  outstanding == 2**seq_width.
- err_underflow  out  1  sticky: a completion was seen while outstanding == 0.

Behaviour:
- Reset (synchronous, active-high):
  - m_ARVALID=0, all m_AR* fields=0, m_ARID=0.
  - seq=0, outstanding=0, full=0, err_underflow=0.
  - s_ARREADY=0 during the reset cycle.
  - Reset asserted mid-operation drops any pending m_AR* request and clears all counts. Responses still in flight after reset are the system's responsibility; they are not counted.
- Accept condition:
  - acc = s_ARVALID & s_ARREADY.
  - s_ARREADY = !reset & !full & (!m_ARVALID | m_ARREADY). Combinational; never depends on s_ARVALID.
- Register slice:
  - On acc, load m_AR* from s_AR* and m_ARID = {seq, ID}. Set m_ARVALID=1 the next cycle, so latency is 1 cycle.
  - If m_ARVALID & m_ARREADY & !acc, clear m_ARVALID.
  - While m_ARVALID & !m_ARREADY, m_AR* and m_ARID hold stable (AXI rule).
  - Back-to-back throughput: 1 request/cycle while m_ARREADY=1 and not full.
- Sequence allocation:
  - On acc, seq <= seq+1, modulo 2**seq_width (wraps 2**seq_width−1 → 0).
  - Tags are issued strictly in order; there is no reuse until the wrap.
- Completion:
  - cmp = RVALID & RREADY & RLAST & (RID[ID_width-1:0]==ID).
  - Only the last beat of a burst counts; the sequence bits of RID are not checked here.
- Outstanding counter (seq_width+1 bits):
  - acc & !cmp → +1.
  - cmp & !acc → −1.
  - acc & cmp → unchanged.
  - cmp with outstanding==0 and no acc → stays 0 and sets err_underflow (sticky until reset).
  - full is registered-equivalent: outstanding==2**seq_width.
  - At full, s_ARREADY=0. A completion in the same cycle re-opens acceptance on the next cycle, not the same cycle; this avoids a comb path from R to AR.
- Counting point:
  - Outstanding counts from acceptance, not from m-side issue, so the request held in the slice is already counted.
  - Hence outstanding ≤ 2**seq_width always, and no two live requests share a seq.
- Derived status:
  - No explicit FSM. State is the pair (m_ARVALID, outstanding).
  - Idle = !m_ARVALID & outstanding==0.

Decomposition:
- Package axi_rd_pkg:
  - ID_W / SEQ_W defaults.
  - ARLEN/ARSIZE/ARBURST widths.
  - Burst-type constants FIXED/INCR/WRAP.
  - Typedef ar_payload_t {addr, len, size, burst}.
- Sub-module ar_reg_slice: generic one-deep valid/ready register holding ar_payload_t plus ID. The tagger instantiates it and adds the seq/outstanding logic around it.

Test Plan:
- Reset for 2 cycles, then one request ARADDR=0x100, ARLEN=3, m_ARREADY=1 → m_ARVALID on the next cycle, m_ARID=6'b0000_00, outstanding=1. After 4 R beats with RLAST on the 4th and RID=6'b0000_00 → outstanding=0.
- 16 back-to-back requests, m_ARREADY=1, no responses:
  - m_ARID seq fields are 0..15 in order.
  - full=1 after the 16th accept, and s_ARREADY=0.
  - A 17th request is held; one completion → accepted on the following cycle with seq=0 (wrap).
- m_ARREADY=0 for 5 cycles with a request pending → m_AR* stable, s_ARREADY=0, outstanding=1. Second request accepted in the cycle m_ARREADY rises.
- Same-cycle acc and cmp with outstanding=3 → outstanding stays 3 and seq advances by 1. Completion with RID low bits ≠ ID → ignored.
- Completion at outstanding=0 → outstanding stays 0, err_underflow=1 and persists until reset.
- reset asserted while m_ARVALID=1 and outstanding=7 → next cycle m_ARVALID=0, outstanding=0, seq=0, err_underflow=0.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared AXI read-address types and widths for the ARID sequence tagger.
package axi_rd_pkg;

  localparam int unsigned ID_W    = 2;
  localparam int unsigned SEQ_W   = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_payload_t;

endpackage

// File: rtl/arid_seq_tagger_if.sv
// AR request/issue channels plus the observed R handshake of the tagger.
interface arid_seq_tagger_if
  import axi_rd_pkg::*;
#(
  parameter int unsigned ID_width   = ID_W,
  parameter int unsigned seq_width  = SEQ_W,
  parameter int unsigned ADDR_WIDTH = ADDR_W
);
  localparam int unsigned TAG_W = ID_width + seq_width;

  logic                  s_ARVALID;
  logic                  s_ARREADY;
  logic [ADDR_WIDTH-1:0] s_ARADDR;
  logic [LEN_W-1:0]      s_ARLEN;
  logic [SIZE_W-1:0]     s_ARSIZE;
  logic [BURST_W-1:0]    s_ARBURST;

  logic                  m_ARVALID;
  logic                  m_ARREADY;
  logic [TAG_W-1:0]      m_ARID;
  logic [ADDR_WIDTH-1:0] m_ARADDR;
  logic [LEN_W-1:0]      m_ARLEN;
  logic [SIZE_W-1:0]     m_ARSIZE;
  logic [BURST_W-1:0]    m_ARBURST;

  logic [TAG_W-1:0]      RID;
  logic                  RVALID;
  logic                  RREADY;
  logic                  RLAST;

  modport slave (
    input  s_ARVALID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST,
    output s_ARREADY,
    output m_ARVALID, m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST,
    input  m_ARREADY,
    input  RID, RVALID, RREADY, RLAST
  );

  modport master (
    output s_ARVALID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST,
    input  s_ARREADY,
    input  m_ARVALID, m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST,
    output m_ARREADY,
    output RID, RVALID, RREADY, RLAST
  );

endinterface

// File: rtl/ar_reg_slice.sv
// One-deep valid/ready register slice carrying an AR payload and its tag.
module ar_reg_slice
  import axi_rd_pkg::*;
#(
  parameter int unsigned TAG_W = ID_W + SEQ_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             block_i,
  input  logic             in_valid_i,
  output logic             in_ready_c,
  input  ar_payload_t      in_data_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output ar_payload_t      out_data_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic             valid_q, valid_d;
  ar_payload_t      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             load_c;

  // Slot is free when empty or draining this cycle; block_i lets the owner stall intake.
  assign in_ready_c = !reset && !block_i && (!valid_q || out_ready_i);
  assign load_c     = in_valid_i && in_ready_c;

  // Load on intake, otherwise drop valid once the downstream handshake completes.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load_c) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      tag_d   = in_tag_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slice registers; payload cleared on reset so idle outputs read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_tag_o   = tag_q;

endmodule

// File: rtl/arid_seq_tagger.sv
// Tags AR requests with {seq, ID} and bounds outstanding bursts to the seq space.
module arid_seq_tagger
  import axi_rd_pkg::*;
#(
  parameter int unsigned           ID_width   = ID_W,
  parameter logic [ID_width-1:0]   ID         = '0,
  parameter int unsigned           seq_width  = SEQ_W,
  parameter int unsigned           ADDR_WIDTH = ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  arid_seq_tagger_if.slave     bus,
  output logic [seq_width:0]   outstanding,
  output logic                 full,
  output logic                 err_underflow
);

  localparam int unsigned TAG_W   = ID_width + seq_width;
  localparam int unsigned OUT_W   = seq_width + 1;
  localparam int unsigned MAX_OUT = 32'(1) << seq_width;

  logic [seq_width-1:0] seq_q, seq_d;
  logic [OUT_W-1:0]     outs_q, outs_d;
  logic                 full_q, full_d;
  logic                 err_q, err_d;
  logic                 s_ready_c, acc_c, cmp_c;
  ar_payload_t          in_data_c, out_data_c;
  logic [TAG_W-1:0]     out_tag_c;
  logic                 unused_rid_seq;

  assign in_data_c = '{addr:  ADDR_W'(bus.s_ARADDR),
                       len:   bus.s_ARLEN,
                       size:  bus.s_ARSIZE,
                       burst: bus.s_ARBURST};

  ar_reg_slice #(.TAG_W(TAG_W)) u_slice (
    .clk         (clk),
    .reset       (reset),
    .block_i     (full_q),
    .in_valid_i  (bus.s_ARVALID),
    .in_ready_c  (s_ready_c),
    .in_data_i   (in_data_c),
    .in_tag_i    ({seq_q, ID}),
    .out_valid_o (bus.m_ARVALID),
    .out_ready_i (bus.m_ARREADY),
    .out_data_o  (out_data_c),
    .out_tag_o   (out_tag_c)
  );

  assign bus.s_ARREADY = s_ready_c;
  assign bus.m_ARID    = out_tag_c;
  assign bus.m_ARADDR  = ADDR_WIDTH'(out_data_c.addr);
  assign bus.m_ARLEN   = out_data_c.len;
  assign bus.m_ARSIZE  = out_data_c.size;
  assign bus.m_ARBURST = out_data_c.burst;

  // Only the ID field of RID selects completions; seq bits belong to the downstream checker.
  assign acc_c          = bus.s_ARVALID && s_ready_c;
  assign cmp_c          = bus.RVALID && bus.RREADY && bus.RLAST && (bus.RID[ID_width-1:0] == ID);
  assign unused_rid_seq = ^bus.RID[TAG_W-1:ID_width];

  // Seq allocation and outstanding accounting from acceptance to last R beat.
  always_comb begin
    seq_d  = seq_q;
    outs_d = outs_q;
    err_d  = err_q;
    if (acc_c) begin
      seq_d = seq_q + seq_width'(1);
    end
    if (acc_c && !cmp_c) begin
      outs_d = outs_q + OUT_W'(1);
    end else if (cmp_c && !acc_c) begin
      if (outs_q == '0) begin
        err_d = 1'b1;
      end else begin
        outs_d = outs_q - OUT_W'(1);
      end
    end
    full_d = (outs_d == OUT_W'(MAX_OUT));
  end

  // Counter state; full is registered so a completion re-opens intake a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q  <= '0;
      outs_q <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      outs_q <= outs_d;
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

  assign outstanding   = outs_q;
  assign full          = full_q;
  assign err_underflow = err_q;

endmodule
